// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter with registered binary grant index and bounded tenure.
// Every release is followed by one idle turnaround cycle before re-arbitration.
module rr_grant_encoder #(
    parameter int WIDTH    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2**WIDTH-1:0]   req,
    output logic                  gnt_vld,
    output logic [WIDTH-1:0]      gnt_idx,
    output logic                  gnt_expired
);

    localparam int N  = 2**WIDTH;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    logic             exp_q, exp_d;

    logic [WIDTH-1:0] win;
    logic             any_req;
    logic             drop;
    logic             tmo;
    logic             rel;

    // Scan downward so the candidate closest to ptr overwrites the rest.
    always_comb begin
        win     = ptr_q;
        any_req = |req;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[ptr_q + WIDTH'(k)]) begin
                win = ptr_q + WIDTH'(k);
            end
        end
    end

    assign drop = !req[idx_q];
    assign tmo  = (hold_q == HW'(MAX_HOLD));
    assign rel  = drop || tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            exp_q   <= exp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        hold_d = hold_q;
        idx_d  = idx_q;
        vld_d  = vld_q;
        exp_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                if (any_req) begin
                    idx_d  = win;
                    vld_d  = 1'b1;
                    hold_d = HW'(1);
                end
            end
            GRANT: begin
                if (rel) begin
                    vld_d  = 1'b0;
                    ptr_d  = idx_q + WIDTH'(1);
                    hold_d = '0;
                    // A coincident drop wins, so expiry flags only a live request.
                    exp_d  = tmo && !drop;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                vld_d  = 1'b0;
                hold_d = '0;
            end
        endcase
    end

    assign gnt_vld     = vld_q;
    assign gnt_idx     = idx_q;
    assign gnt_expired = exp_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder: vector table plus reset, MAX_HOLD=1
// and full-rotation sequences.
module tb_rr_grant_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;

    logic       vld0, exp0;
    logic [2:0] idx0;
    logic       vld1, exp1;
    logic [2:0] idx1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] req;
        logic       vld;
        logic [2:0] idx;
        logic       expd;
    } vec_t;

    vec_t tbl[$];

    rr_grant_encoder #(.WIDTH(3), .MAX_HOLD(4)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt_vld(vld0), .gnt_idx(idx0), .gnt_expired(exp0)
    );

    rr_grant_encoder #(.WIDTH(3), .MAX_HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt_vld(vld1), .gnt_idx(idx1), .gnt_expired(exp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [4:0] act,
                       input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got vld/idx/exp=%b/%0d/%b required %b/%0d/%b",
                     name, act[4], act[3:1], act[0], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic add(input logic [7:0] r, input logic v,
                       input logic [2:0] i, input logic e);
        vec_t t;
        t.req = r; t.vld = v; t.idx = i; t.expd = e;
        tbl.push_back(t);
    endtask

    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        // Idle with no requests.
        for (int i = 0; i < 10; i++) add(8'h00, 1'b0, 3'd0, 1'b0);
        // Drop release of requester 5.
        add(8'h20, 1'b1, 3'd5, 1'b0);
        add(8'h20, 1'b1, 3'd5, 1'b0);
        add(8'h20, 1'b1, 3'd5, 1'b0);
        add(8'h00, 1'b0, 3'd5, 1'b0);
        add(8'h00, 1'b0, 3'd5, 1'b0);
        // Grant 6, then wrap past clear bit 7 to 0 and 1.
        add(8'h40, 1'b1, 3'd6, 1'b0);
        add(8'h00, 1'b0, 3'd6, 1'b0);
        add(8'h03, 1'b1, 3'd0, 1'b0);
        add(8'h03, 1'b1, 3'd0, 1'b0);
        add(8'h02, 1'b0, 3'd0, 1'b0);
        add(8'h02, 1'b1, 3'd1, 1'b0);
        add(8'h00, 1'b0, 3'd1, 1'b0);
        // Drop coincides with hold_cnt==MAX_HOLD.
        for (int i = 0; i < 4; i++) add(8'h08, 1'b1, 3'd3, 1'b0);
        add(8'h00, 1'b0, 3'd3, 1'b0);
        // Pure timeout of sole requester 4, then re-grant.
        for (int i = 0; i < 4; i++) add(8'h10, 1'b1, 3'd4, 1'b0);
        add(8'h10, 1'b0, 3'd4, 1'b1);
        add(8'h10, 1'b1, 3'd4, 1'b0);
        add(8'h00, 1'b0, 3'd4, 1'b0);

        @(posedge clk);
        #1;
        chk("reset_state", {vld0, idx0, exp0}, 5'b0);
        #2 rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].req);
            chk($sformatf("vec%0d", i), {vld0, idx0, exp0},
                {tbl[i].vld, tbl[i].idx, tbl[i].expd});
        end

        // Reset mid-grant, then re-arbitrate from ptr=0.
        step(8'h10);
        chk("pre_rst_grant", {vld0, idx0, exp0}, {1'b1, 3'd4, 1'b0});
        #3 rst_n = 1'b0;
        #1;
        chk("async_clear", {vld0, idx0, exp0}, 5'b0);
        @(posedge clk);
        #1;
        chk("held_in_reset", {vld0, idx0, exp0}, 5'b0);
        #2 rst_n = 1'b1;
        step(8'h10);
        chk("post_rst_grant", {vld0, idx0, exp0}, {1'b1, 3'd4, 1'b0});
        chk("mh1_grant", {vld1, idx1, exp1}, {1'b1, 3'd4, 1'b0});
        step(8'h10);
        chk("mh1_timeout", {vld1, idx1, exp1}, {1'b0, 3'd4, 1'b1});
        chk("mh4_hold2", {vld0, idx0, exp0}, {1'b1, 3'd4, 1'b0});
        step(8'h10);
        chk("mh1_regrant", {vld1, idx1, exp1}, {1'b1, 3'd4, 1'b0});
        step(8'h00);
        chk("mh4_drop", {vld0, idx0, exp0}, {1'b0, 3'd4, 1'b0});
        chk("mh1_drop", {vld1, idx1, exp1}, {1'b0, 3'd4, 1'b0});

        // Full rotation with all requests held high.
        do_reset();
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 4; c++) begin
                step(8'hFF);
                chk($sformatf("rot%0d_c%0d", g, c), {vld0, idx0, exp0},
                    {1'b1, 3'(g % 8), 1'b0});
            end
            step(8'hFF);
            chk($sformatf("rot%0d_gap", g), {vld0, idx0, exp0},
                {1'b0, 3'(g % 8), 1'b1});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_grant_encoder.md
Name: rr_grant_encoder

Overview:
- Round-robin arbiter for 2**WIDTH requesters.
- Outputs the winner as a registered binary index plus a valid flag.
- Sits directly upstream of the 3-to-8 one-hot decoder: gnt_idx drives the decoder input, and the decoded one-hot selects the granted unit.
- Enforces a bounded grant tenure and fair rotation.

Parameters:
- WIDTH, 3, index width; requester count N = 2**WIDTH.
- MAX_HOLD, 16, maximum consecutive cycles a single grant may be held; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2**WIDTH  request vector; bit i high = requester i wants the resource.
- gnt_vld  output  1  high while a grant is held.
- gnt_idx  output  WIDTH  index of the current or last granted requester; stable for the whole tenure.
- gnt_expired  output  1  one-cycle pulse: the last grant was revoked by timeout while its request was still high.

Behaviour:
- Reset state (async on rst_n low, all registers):
  - state=IDLE, gnt_vld=0, gnt_idx=0, gnt_expired=0.
  - ptr=0, hold_cnt=0.
- Reset asserted mid-grant clears everything immediately; no release cycle occurs.
- State IDLE (gnt_vld=0):
  - If req==0, stay in IDLE.
  - Otherwise select the winner: the first set bit of req searching upward from ptr, modulo N (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
  - On the next edge: gnt_idx<=winner, gnt_vld<=1, hold_cnt<=1, state<=GRANT.
  - Latency: req observed in cycle t gives gnt_vld=1 in cycle t+1.
- State GRANT (gnt_vld=1). Release is evaluated every cycle:
  - Drop release: req[gnt_idx]==0.
  - Timeout release: hold_cnt==MAX_HOLD.
  - If either release holds, on the next edge:
    - state<=IDLE, gnt_vld<=0.
    - ptr<=gnt_idx+1, with wrap N-1 -> 0.
    - hold_cnt<=0.
  - Otherwise hold_cnt<=hold_cnt+1 and gnt_idx is unchanged.
  - Both releases in the same cycle: treat as a drop release, so gnt_expired stays 0.
- Turnaround: every release is followed by exactly one IDLE cycle with gnt_vld=0, even if other requests are pending. Arbitration happens in that IDLE cycle, so back-to-back grants are spaced by one cycle.
- gnt_expired: 1 for exactly the IDLE cycle after a timeout release where req[gnt_idx] was still 1 at release; 0 otherwise.
- gnt_idx keeps its last value while gnt_vld=0. Downstream must qualify with gnt_vld.
- Fairness: ptr advances past the last winner, so with all requests held high, grants rotate 0,1,...,N-1,0. No requester waits more than N-1 tenures.
- Requests for other indices that change during GRANT have no effect until the next IDLE.
- hold_cnt width: clog2(MAX_HOLD+1). It never exceeds MAX_HOLD.
- MAX_HOLD=1: every grant lasts exactly one cycle.
- Fully synchronous except reset.
- No combinational path from req to any output; all outputs come straight from flops.

Test Plan:
- Reset, then req=8'h00 for 10 cycles -> gnt_vld stays 0, gnt_idx=0, gnt_expired=0.
- Single request, drop release: req=8'h20 at cycle t, dropped to 0 at t+5 -> gnt_vld=1, gnt_idx=5 for cycles t+1..t+5; gnt_vld=0 at t+6; gnt_expired never set.
- Fair rotation: req=8'hFF held, MAX_HOLD=4 -> gnt_idx sequence 0,1,2,...,7,0. Each grant lasts 4 cycles, separated by one gnt_vld=0 cycle with gnt_expired=1.
- Wrap search: after a grant to 6, req=8'h03 -> next grant is 0, then 1; bit 7 stays clear so it is skipped.
- Timeout vs drop coincidence: req[3] drops on the same cycle hold_cnt==MAX_HOLD -> release occurs, gnt_expired=0.
- Reset mid-grant: rst_n pulsed low while gnt_vld=1, gnt_idx=4 -> outputs clear asynchronously. After release with req=8'h10 still high, re-arbitration from ptr=0 grants 4 again one cycle later.
